// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Pipeline instruction-fetch stage. Owns the program counter,
//               drives the word-aligned fetch address to a zero-latency
//               instruction memory and captures the returned word into the
//               IF/ID pipeline register. Decode-stage stall, flush and
//               branch/jump redirects are handled here. The stage also keeps
//               fetch/stall statistics and a sticky misaligned-redirect flag.
// Ports       : Clk, Reset           - clock, synchronous active-high reset
//               Stall, Flush         - hold stage / squash current fetch
//               BranchTaken/Target   - taken-branch redirect from ID
//               Jump/JumpTarget      - jump redirect from ID (beats branch)
//               Instruction          - memory read data for Address
//               Address              - fetch byte address (= PC)
//               IFID_*               - IF/ID register contents
//               FetchCount           - valid instructions delivered to IF/ID
//               StallCount           - cycles held by Stall
//               AlignFault           - sticky: redirect target not aligned
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] Instruction,
    output logic [31:0] Address,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount,
    output logic        AlignFault
);

    // Byte-address mask for the instruction memory; PC+4 wraps within it.
    localparam logic [31:0] c_pc_mask = 32'(4 * IMEM_WORDS - 1);

    logic [31:0] pc_q,         pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q,   ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] fetch_cnt_q,  fetch_cnt_d;
    logic [31:0] stall_cnt_q,  stall_cnt_d;
    logic        align_q,      align_d;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    // Jump has priority over a simultaneous taken branch.
    assign w_redirect = Jump | BranchTaken;
    assign w_target   = Jump ? JumpTarget : BranchTarget;
    assign w_pc_plus4 = (pc_q + 32'd4) & c_pc_mask;

    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        align_d      = align_q;

        // Program counter: a redirect overrides Stall.
        if (w_redirect) begin
            pc_d = w_target & ~32'd3;
            if (w_target[1:0] != 2'b00) begin
                align_d = 1'b1;
            end
        end else if (!Stall) begin
            pc_d = w_pc_plus4;
        end

        // IF/ID: squash the wrong-path word on any redirect or flush.
        if (w_redirect || Flush) begin
            ifid_instr_d = NOP_WORD;
            ifid_pc4_d   = 32'd0;
            ifid_valid_d = 1'b0;
        end else if (!Stall) begin
            ifid_instr_d = Instruction;
            ifid_pc4_d   = w_pc_plus4;
            ifid_valid_d = 1'b1;
            fetch_cnt_d  = fetch_cnt_q + 32'd1;
        end

        if (Stall && !w_redirect) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_WORD;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
            fetch_cnt_q  <= 32'd0;
            stall_cnt_q  <= 32'd0;
            align_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            align_q      <= align_d;
        end
    end

    assign Address          = pc_q;
    assign IFID_Instruction = ifid_instr_q;
    assign IFID_PCPlus4     = ifid_pc4_q;
    assign IFID_Valid       = ifid_valid_q;
    assign FetchCount       = fetch_cnt_q;
    assign StallCount       = stall_cnt_q;
    assign AlignFault       = align_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. Memory word i holds i*3.
//               Each driven cycle pushes the expected post-edge state onto a
//               scoreboard queue; it is popped and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'd0;
    logic        Jump = 1'b0;
    logic [31:0] JumpTarget = 32'd0;
    logic [31:0] Instruction;
    logic [31:0] Address;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
    logic        AlignFault;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .NOP_WORD   (32'h0000_0000),
        .IMEM_WORDS (1024)
    ) u_dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Stall            (Stall),
        .Flush            (Flush),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .Jump             (Jump),
        .JumpTarget       (JumpTarget),
        .Instruction      (Instruction),
        .Address          (Address),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid),
        .FetchCount       (FetchCount),
        .StallCount       (StallCount),
        .AlignFault       (AlignFault)
    );

    always #5 Clk = ~Clk;

    // Instruction memory model: word i = i*3.
    assign Instruction = {2'b00, Address[31:2]} * 32'd3;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pp4;
        logic        val;
        logic [31:0] fc;
        logic [31:0] sc;
        logic        af;
    } exp_t;

    exp_t m;       // reference model state
    exp_t sb_q[$]; // scoreboard

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the result, then compare after the edge.
    task automatic step(input logic rst, input logic st, input logic fl,
                        input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt);
        exp_t        n;
        logic        redir;
        logic [31:0] tgt;
        exp_t        e;
        @(negedge Clk);
        Reset = rst; Stall = st; Flush = fl;
        BranchTaken = br; BranchTarget = bt; Jump = jp; JumpTarget = jt;

        n = m;
        redir = jp | br;
        tgt   = jp ? jt : bt;
        if (rst) begin
            n.pc = 32'd0; n.ins = 32'd0; n.pp4 = 32'd0; n.val = 1'b0;
            n.fc = 32'd0; n.sc = 32'd0; n.af = 1'b0;
        end else begin
            if (redir) begin
                n.pc = {tgt[31:2], 2'b00};
                if (tgt[1:0] != 2'b00) n.af = 1'b1;
            end else if (!st) begin
                n.pc = (m.pc + 32'd4) % 32'd4096;
            end
            if (redir || fl) begin
                n.ins = 32'd0; n.pp4 = 32'd0; n.val = 1'b0;
            end else if (!st) begin
                n.ins = (m.pc / 32'd4) * 32'd3;
                n.pp4 = (m.pc + 32'd4) % 32'd4096;
                n.val = 1'b1;
                n.fc  = m.fc + 32'd1;
            end
            if (st && !redir) n.sc = m.sc + 32'd1;
        end
        m = n;
        sb_q.push_back(n);

        @(posedge Clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("Address",    Address,            e.pc);
            check("IFID_Instr", IFID_Instruction,   e.ins);
            check("IFID_PC4",   IFID_PCPlus4,       e.pp4);
            check("IFID_Valid", {31'd0, IFID_Valid}, {31'd0, e.val});
            check("FetchCount", FetchCount,         e.fc);
            check("StallCount", StallCount,         e.sc);
            check("AlignFault", {31'd0, AlignFault}, {31'd0, e.af});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        m = '{pc: 32'd0, ins: 32'd0, pp4: 32'd0, val: 1'b0, fc: 32'd0, sc: 32'd0, af: 1'b0};

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("rst_addr", Address, 32'd0);

        // Free running: fetch words 0 and 1, PC reaches 8.
        run(2);
        check("free_addr8", Address, 32'd8);
        check("free_ins1",  IFID_Instruction, 32'd3);

        // Stall 3 cycles at PC = 8, then release.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("stall_pc",  Address, 32'd8);
        check("stall_cnt", StallCount, 32'd3);
        run(1);
        check("rel_ins",  IFID_Instruction, 32'd6);
        check("rel_addr", Address, 32'd12);
        check("rel_fc",   FetchCount, 32'd3);

        // Branch with simultaneous stall: redirect wins.
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
        check("br_pc",    Address, 32'h40);
        check("br_valid", {31'd0, IFID_Valid}, 32'd0);
        run(1);
        check("br_ins16", IFID_Instruction, 32'd48);

        // Jump beats branch; then a misaligned jump sets the sticky fault.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h80);
        check("jmp_pc", Address, 32'h80);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h82);
        check("jmp_al_pc", Address, 32'h80);
        check("jmp_af",    {31'd0, AlignFault}, 32'd1);
        run(10);
        check("af_sticky", {31'd0, AlignFault}, 32'd1);

        // Misaligned branch target, fetched aligned.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h107, 1'b0, 32'd0);
        check("br_al_pc", Address, 32'h104);

        // PC wrap at the top of memory.
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFC);
        run(1);
        check("wrap_pc",  Address, 32'd0);
        check("wrap_pc4", IFID_PCPlus4, 32'd0);
        run(2);

        // Flush alone advances PC; flush with stall holds PC.
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        run(2);

        // Random mix of controls against the model.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] r;
            r = $urandom;
            step(1'b0, r[0] & r[1], r[2] & r[3] & r[4], r[5] & r[6] & r[7],
                 $urandom_range(0, 4095), r[8] & r[9] & r[10] & r[11],
                 $urandom_range(0, 4095));
        end

        // Reset while stalled at PC = 0x30.
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h30);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("pre_rst_pc", Address, 32'h30);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("rst_pc",  Address, 32'd0);
        check("rst_val", {31'd0, IFID_Valid}, 32'd0);
        check("rst_fc",  FetchCount, 32'd0);
        check("rst_sc",  StallCount, 32'd0);
        check("rst_af",  {31'd0, AlignFault}, 32'd0);
        run(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Pipeline instruction-fetch stage, directly upstream of the instruction memory.
- Owns the program counter and drives the word-aligned fetch address.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirects from the decode stage, and exposes fetch statistics plus an alignment fault flag.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_WORD, 32'h00000000, bubble instruction written into IF/ID on flush, redirect or reset (sll $0,$0,0).
- IMEM_WORDS, 1024, instruction memory depth in words. The PC wraps modulo 4*IMEM_WORDS bytes. Must be a power of 2.

Ports:
- Clk, input, 1, rising-edge clock.
- Reset, input, 1, synchronous active-high reset.
- Stall, input, 1, hazard stall from ID: hold PC and IF/ID.
- Flush, input, 1, squash the instruction currently being fetched.
- BranchTaken, input, 1, resolved taken branch in ID.
- BranchTarget, input, 32, branch target byte address.
- Jump, input, 1, jump in ID.
- JumpTarget, input, 32, jump target byte address.
- Instruction, input, 32, combinational read data from instruction memory.
- Address, output, 32, fetch byte address to instruction memory (= PC).
- IFID_Instruction, output, 32, registered instruction to decode.
- IFID_PCPlus4, output, 32, registered PC+4 of that instruction.
- IFID_Valid, output, 1, IF/ID holds a real (non-bubble) instruction.
- FetchCount, output, 32, count of valid instructions delivered to IF/ID.
- StallCount, output, 32, count of cycles Stall held the stage.
- AlignFault, output, 1, sticky flag: a redirect target had bits[1:0] != 0.

Behaviour:
- All state updates on the rising edge of Clk. Reset is synchronous and active-high and overrides everything.
- Reset values:
  - PC = RESET_PC.
  - IFID_Instruction = NOP_WORD, IFID_PCPlus4 = 0, IFID_Valid = 0.
  - FetchCount = 0, StallCount = 0, AlignFault = 0.
- Address = PC, combinational from the register. Instruction is sampled in the same cycle (zero-latency memory read).
- PCPlus4 = (PC + 4) masked to log2(4*IMEM_WORDS) bits. The upper bits are zero, so the PC wraps from 4*IMEM_WORDS-4 to 0.
- Next-PC priority, highest first:
  1. Reset.
  2. Jump: PC <= JumpTarget & ~3.
  3. BranchTaken: PC <= BranchTarget & ~3.
  4. Stall: PC holds.
  5. Otherwise: PC <= PCPlus4.
- A redirect (Jump or BranchTaken) overrides a simultaneous Stall.
- If the selected redirect target has bits[1:0] != 0, AlignFault <= 1. It stays set until Reset. The fetch proceeds at the aligned address.
- IF/ID update priority:
  1. Reset.
  2. Jump, BranchTaken or Flush: load bubble (NOP_WORD, PCPlus4 = 0, Valid = 0). This squashes the wrong-path fetch, giving a one-cycle branch penalty.
  3. Stall: hold all IF/ID fields.
  4. Otherwise: load Instruction, PCPlus4, Valid = 1.
- Flush alone (no redirect) bubbles IF/ID and, if Stall is low, still advances PC. Flush+Stall without a redirect: IF/ID is bubbled and PC holds.
- Counters:
  - FetchCount increments by 1 exactly on cycles where IF/ID loads with Valid = 1.
  - StallCount increments on cycles where Stall = 1 and no redirect is present.
  - Both wrap at 2^32 with no saturation.
- Reset asserted mid-stall or mid-redirect discards all pending state. The first fetch after Reset deasserts is at RESET_PC.
- No combinational path from any input to Address. Inputs affect only registered next-state.

Test Plan:
- Reset, then 4 free-running cycles with memory word i = i*3.
  - Address steps 0, 4, 8, 12.
  - IFID_Instruction = 0, 3, 6 with PCPlus4 = 4, 8, 12.
  - FetchCount = 3 at cycle 4.
- Stall high for 3 cycles at PC = 8.
  - PC stays 8 and the IF/ID fields are frozen.
  - StallCount = 3.
  - After release, IFID_Instruction = 6 (word 2) and PC advances to 12.
- BranchTaken with BranchTarget = 0x40 and Stall = 1 in the same cycle.
  - Next cycle: PC = 0x40, IFID_Valid = 0, IFID_Instruction = NOP_WORD.
  - One cycle later: IFID_Instruction = 48 (word 16).
- Jump = 1 with JumpTarget = 0x80 and BranchTaken = 1 with BranchTarget = 0x20 together.
  - PC = 0x80 (jump wins).
  - JumpTarget = 0x82 instead gives PC = 0x80 and AlignFault = 1, held through 10 further cycles.
- PC at 0xFFC with IMEM_WORDS = 1024, no stall.
  - Next PC = 0x000.
  - IFID_PCPlus4 = 0x000 for the instruction fetched from 0xFFC.
- Reset asserted while Stall = 1 and PC = 0x30.
  - Next cycle: PC = 0, IFID_Valid = 0, all counters 0, AlignFault = 0.
